ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Parametrised PS/2 keyboard receiver: samples the keyboard's open-collector `ps2_clk`/`ps2_data` lines in the system clock domain and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). It decodes E0 (extended) and F0 (break) prefixes into complete key events. Those events go into a FIFO with a valid/ready handshake. It also drives held-level outputs for the left and right arrow keys. It replaces the fixed arrow-only driver and sits between the keyboard pins and the game/control logic.

## Interface
- `SYNC_STAGES`, 2, flops in each pin synchroniser (>=2)
- `FIFO_DEPTH`, 8, event FIFO entries (power of two, >=2)
- `TIMEOUT_CYCLES`, 50000, clk cycles without a falling `ps2_clk` edge before a partial frame is abandoned
- `clk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ps2_clk`  in  1  raw PS/2 clock pin (asynchronous)
- `ps2_data`  in  1  raw PS/2 data pin (asynchronous)
- `evt_valid`  out  1  FIFO not empty
- `evt_ready`  in  1  consumer accepts head event
- `evt_code`  out  8  scan code of head event
- `evt_ext`  out  1  head event had E0 prefix
- `evt_brk`  out  1  head event had F0 prefix (key release)
- `left_arrow`  out  1  level: E0 6B held
- `right_arrow`  out  1  level: E0 74 held
- `err_parity`  out  1  one-cycle pulse on parity error
- `err_frame`  out  1  one-cycle pulse on bad start/stop bit or timeout
- `err_overflow`  out  1  one-cycle pulse when an event is dropped because FIFO full

## Operation
- Both pins pass through `SYNC_STAGES` flops, reset value 1. A falling edge is detected when the previous synchronised `ps2_clk` is 1 and the current one is 0.
- Deframer FSM states:
  - IDLE:
    - On a falling edge with data=0 -> go to DATA, bit count 0.
    - On a falling edge with data=1 -> pulse `err_frame`, stay in IDLE.
  - DATA: shift in 8 bits LSB-first on successive falling edges, then go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: on the falling edge check both of:
    - the stop bit must be 1;
    - `^{data,parity}` must be 1.
    - Parity failure -> `err_parity`. Stop failure -> `err_frame`. Both failing -> both pulse.
    - On any failure, drop the byte and clear the prefix flags.
    - On success, emit `byte_done` for one cycle. Return to IDLE.
- Timeout: in any state other than IDLE, a counter counts cycles since the last falling edge.
  - At `TIMEOUT_CYCLES` -> pulse `err_frame`, return to IDLE, clear the prefix flags.
  - The counter is held at 0 in IDLE.
- Decoder, on `byte_done`:
  - E0 -> set `ext`.
  - F0 -> set `brk`.
  - Any other byte -> push `{ext,brk,code}` to the FIFO, then clear both flags.
  - Arrow levels:
    - ext=1 with code 6B -> `left_arrow <= ~brk`.
    - ext=1 with code 74 -> `right_arrow <= ~brk`.
  - Arrow levels update even when the push is dropped.
- FIFO:
  - Pop when `evt_valid && evt_ready`.
  - Push while full -> drop the new event and pulse `err_overflow`.
  - Push and pop in the same cycle while full -> both succeed; no overflow.
  - Pointers wrap modulo `FIFO_DEPTH`. A separate count distinguishes full from empty.
- Reset values:
  - All outputs 0.
  - FSM IDLE; flags, counters and FIFO pointers 0.
  - Synchroniser flops 1.
  - Reset asserted mid-frame discards the partial frame and all queued events.

## Timing
- A pin edge is visible as a detected falling edge `SYNC_STAGES`+1 clk cycles later (3 at default).
- `byte_done` is registered 1 cycle after the stop-bit edge is detected.
- FIFO write and arrow level update happen 1 cycle after `byte_done`. `evt_valid` rises the same cycle the write is visible, i.e. 2 cycles after stop-edge detection.
- `evt_code`/`evt_ext`/`evt_brk` show the FIFO head combinationally from registered storage. The next entry appears the cycle after a pop.
- Error pulses are exactly one cycle wide, registered.
- Required: `ps2_clk` low and high phases each >= `SYNC_STAGES`+2 clk cycles.

## Test plan
- Send frames E0 (data E0, parity 0) then 6B (parity 0) with `evt_ready`=0:
  - `left_arrow`=1;
  - one event: code=6B, ext=1, brk=0.
- Send frames E0, F0 (parity 1), 6B:
  - `left_arrow` returns to 0;
  - event ext=1, brk=1.
- Send E0 74 (parity 1) while left is held:
  - `right_arrow`=1 and `left_arrow` stays 1.
- Send 1C with parity bit flipped to 1:
  - `err_parity` pulses once;
  - no event, `evt_valid` unchanged.
- Send 4 bits of a frame, then idle `TIMEOUT_CYCLES`:
  - `err_frame` pulses;
  - a following valid 1C frame yields an event with code=1C, ext=0, brk=0.
- `evt_ready`=0, send `FIFO_DEPTH`+1 frames of 1C:
  - `FIFO_DEPTH` events queued;
  - one `err_overflow` pulse.
  - Then hold `evt_ready`=1: exactly `FIFO_DEPTH` pops in consecutive cycles, then `evt_valid`=0.
  - Assert `rst_n`=0 mid-frame: all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, frame deframer, E0/F0 prefix decoder,
// key-event FIFO with valid/ready handshake and held arrow-key levels.
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       left_arrow,
    output logic       right_arrow,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO   = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] csync_q, csync_d, dsync_q, dsync_d;
    logic       cprev_q, cprev_d;
    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic       byte_done_q, byte_done_d;
    logic       err_par_q, err_par_d, err_frm_q, err_frm_d;
    logic       err_ovf_q, err_ovf_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       left_q, left_d, right_q, right_d;
    logic [9:0] mem_q [FIFO_DEPTH];
    logic [9:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic clk_s, data_s, fall, flag_clr, push, pop, wr_ok;

    assign clk_s  = csync_q[SYNC_STAGES-1];
    assign data_s = dsync_q[SYNC_STAGES-1];
    assign fall   = cprev_q & ~clk_s;

    // Deframer: sync chains, frame FSM and inactivity timeout
    always_comb begin
        csync_d     = {csync_q[SYNC_STAGES-2:0], ps2_clk};
        dsync_d     = {dsync_q[SYNC_STAGES-2:0], ps2_data};
        cprev_d     = clk_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        byte_done_d = 1'b0;
        err_par_d   = 1'b0;
        err_frm_d   = 1'b0;
        flag_clr    = 1'b0;
        if (state_q == S_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO) begin
            tmo_d     = '0;
            state_d   = S_IDLE;
            err_frm_d = 1'b1;
            flag_clr  = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_frm_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = data_s;
                    state_d = S_STOP;
                end
                default: begin
                    err_par_d = ~(^{shift_q, par_q});
                    err_frm_d = ~data_s;
                    if (err_par_d || err_frm_d) flag_clr = 1'b1;
                    else byte_done_d = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Prefix decoder, arrow levels and event FIFO
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        left_d    = left_q;
        right_d   = right_q;
        push      = 1'b0;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (flag_clr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (byte_done_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q && shift_q == 8'h6B) left_d  = ~brk_q;
                if (ext_q && shift_q == 8'h74) right_d = ~brk_q;
            end
        end
        pop       = (cnt_q != '0) && evt_ready;
        wr_ok     = push && ((cnt_q != FULL) || pop);
        err_ovf_d = push && (cnt_q == FULL) && !pop;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = {ext_q, brk_q, shift_q};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        cnt_d = cnt_q + CW'(wr_ok) - CW'(pop);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csync_q     <= '1;
            dsync_q     <= '1;
            cprev_q     <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_done_q <= 1'b0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            csync_q     <= csync_d;
            dsync_q     <= dsync_d;
            cprev_q     <= cprev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_done_q <= byte_done_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_ovf_q   <= err_ovf_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            left_q      <= left_d;
            right_q     <= right_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign evt_valid    = (cnt_q != '0);
    assign evt_ext      = mem_q[rd_ptr_q][9];
    assign evt_brk      = mem_q[rd_ptr_q][8];
    assign evt_code     = mem_q[rd_ptr_q][7:0];
    assign left_arrow   = left_q;
    assign right_arrow  = right_q;
    assign err_parity   = err_par_q;
    assign err_frame    = err_frm_q;
    assign err_overflow = err_ovf_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: directed scenarios plus random byte
// streams checked against a queue-based key-event reference model.
module tb_ps2_keyboard_rx;
    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int H     = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic evt_ready = 1'b0;
    logic evt_valid, evt_ext, evt_brk;
    logic [7:0] evt_code;
    logic left_arrow, right_arrow;
    logic err_parity, err_frame, err_overflow;

    ps2_keyboard_rx #(
        .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_brk(evt_brk), .left_arrow(left_arrow),
        .right_arrow(right_arrow), .err_parity(err_parity),
        .err_frame(err_frame), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    logic [9:0] q_m[$];
    bit ext_m, brk_m, left_m, right_m;

    // Count high cycles of each error pulse
    always @(negedge clk) begin
        if (err_parity) n_par++;
        if (err_frame) n_frm++;
        if (err_overflow) n_ovf++;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(logic [7:0] b);
        if (b == 8'hE0) ext_m = 1'b1;
        else if (b == 8'hF0) brk_m = 1'b1;
        else begin
            if (q_m.size() < DEPTH) q_m.push_back({ext_m, brk_m, b});
            else exp_ovf++;
            if (ext_m && b == 8'h6B) left_m = !brk_m;
            if (ext_m && b == 8'h74) right_m = !brk_m;
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    task automatic send_frame(logic [7:0] b, bit flip, bit bad_stop, int nbits);
        logic [10:0] f;
        f = {!bad_stop, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        if (nbits == 11) begin
            repeat (2 * H) @(negedge clk);
            if (flip || bad_stop) begin
                if (flip) exp_par++;
                if (bad_stop) exp_frm++;
                ext_m = 1'b0;
                brk_m = 1'b0;
            end else begin
                model_byte(b);
            end
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, ".left"}, 32'(left_arrow), 32'(left_m));
        chk({tag, ".right"}, 32'(right_arrow), 32'(right_m));
        chk({tag, ".valid"}, 32'(evt_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0)
            chk({tag, ".head"}, {22'd0, evt_ext, evt_brk, evt_code}, 32'(q_m[0]));
        chk({tag, ".npar"}, 32'(n_par), 32'(exp_par));
        chk({tag, ".nfrm"}, 32'(n_frm), 32'(exp_frm));
        chk({tag, ".novf"}, 32'(n_ovf), 32'(exp_ovf));
    endtask

    task automatic drain(string tag);
        @(negedge clk);
        while (q_m.size() != 0) begin
            chk({tag, ".pvalid"}, 32'(evt_valid), 32'd1);
            chk({tag, ".phead"}, {22'd0, evt_ext, evt_brk, evt_code}, 32'(q_m[0]));
            void'(q_m.pop_front());
            evt_ready = 1'b1;
            @(negedge clk);
        end
        chk({tag, ".empty"}, 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int r;
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(evt_valid), 32'd0);
        chk("rst.left", 32'(left_arrow), 32'd0);
        chk("rst.errs", {29'd0, err_parity, err_frame, err_overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h6B, 0, 0, 11);
        check_state("left_make");
        chk("left_make.lvl", 32'(left_arrow), 32'd1);
        chk("left_make.evt", {22'd0, evt_ext, evt_brk, evt_code}, 32'h26B);

        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h74, 0, 0, 11);
        check_state("right_make");
        chk("right_make.lvl", {30'd0, left_arrow, right_arrow}, 32'd3);

        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h6B, 0, 0, 11);
        check_state("left_brk");
        chk("left_brk.lvl", 32'(left_arrow), 32'd0);
        drain("d1");

        send_frame(8'h1C, 1, 0, 11);
        check_state("parity");
        chk("parity.pulse", 32'(n_par), 32'd1);

        send_frame(8'h1C, 0, 1, 11);
        check_state("stopbit");

        send_frame(8'h1C, 0, 0, 4);
        repeat (TMO + 30) @(negedge clk);
        exp_frm++;
        ext_m = 1'b0;
        brk_m = 1'b0;
        check_state("timeout");
        send_frame(8'h1C, 0, 0, 11);
        check_state("after_tmo");
        chk("after_tmo.evt", {22'd0, evt_ext, evt_brk, evt_code}, 32'h01C);
        drain("d2");

        for (int i = 0; i <= DEPTH; i++) send_frame(8'h1C, 0, 0, 11);
        check_state("overflow");
        chk("overflow.pulse", 32'(n_ovf), 32'd1);
        drain("d3");

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = 8'h6B;
                3: b = 8'h74;
                4: b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 11);
            check_state("rnd");
            if ($urandom_range(0, 7) == 0) drain("rnd_d");
        end

        for (int i = 0; i < 3; i++) send_frame(8'h1C, 0, 0, 11);
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h74, 0, 0, 11);
        send_frame(8'h29, 0, 0, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(evt_valid), 32'd0);
        chk("midrst.evt", {22'd0, evt_ext, evt_brk, evt_code}, 32'd0);
        chk("midrst.arrows", {30'd0, left_arrow, right_arrow}, 32'd0);
        chk("midrst.errs", {29'd0, err_parity, err_frame, err_overflow}, 32'd0);
        q_m.delete();
        ext_m = 1'b0; brk_m = 1'b0; left_m = 1'b0; right_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h1C, 0, 0, 11);
        check_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
